// File: rtl/fifo_word_serializer_pkg.sv
// Shared types and helpers for the FIFO word serializer.
package fifo_ser_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        POP  = 2'd1,
        LOAD = 2'd2,
        SEND = 2'd3
    } ser_state_t;

    localparam int DEF_DATA_W = 32;
    localparam int DEF_OUT_W  = 8;
    localparam int BEATS      = DEF_DATA_W / DEF_OUT_W;

    // Widest word the beat selector handles; callers zero-extend into it.
    localparam int MAX_W = 256;

    // Returns beat idx of a data_w-bit word in the low out_w bits of the result.
    // With msb_first, beat 0 is the top slice of the word.
    function automatic logic [MAX_W-1:0] get_beat(input logic [MAX_W-1:0] word,
                                                  input int              idx,
                                                  input int              data_w,
                                                  input int              out_w,
                                                  input bit              msb_first);
        int sh;
        sh = msb_first ? (data_w - out_w * (idx + 1)) : (out_w * idx);
        return word >> sh;
    endfunction

endpackage

// File: rtl/fifo_word_serializer_if.sv
// FIFO read port plus byte-stream handshake bundled for the serializer.
interface fifo_word_serializer_if #(
    parameter int DATA_W = 32,
    parameter int OUT_W  = 8
);
    logic              fifo_empty;
    logic              fifo_rd_en;
    logic [DATA_W-1:0] fifo_dout;
    logic              m_valid;
    logic              m_ready;
    logic [OUT_W-1:0]  m_data;
    logic              m_last;

    // Serializer side: pops the FIFO, drives the beat stream.
    modport master (
        input  fifo_empty, fifo_dout, m_ready,
        output fifo_rd_en, m_valid, m_data, m_last
    );

    // FIFO + sink side.
    modport slave (
        output fifo_empty, fifo_dout, m_ready,
        input  fifo_rd_en, m_valid, m_data, m_last
    );
endinterface

// File: rtl/fifo_word_serializer.sv
// Pops words from a FIFO and slices them into OUT_W-bit beats on a
// valid/ready stream, marking the final beat of each word.
module fifo_word_serializer
    import fifo_ser_pkg::*;
#(
    parameter int DATA_W    = 32,
    parameter int OUT_W     = 8,
    parameter int MSB_FIRST = 1,
    parameter int CNT_W     = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     en,
    fifo_word_serializer_if.master   io,
    output logic                     busy,
    output logic [CNT_W-1:0]         word_cnt
);

    localparam int N_BEATS = DATA_W / OUT_W;
    localparam int IDX_W   = (N_BEATS > 1) ? $clog2(N_BEATS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_BEATS - 1);

    // Reject word/beat width combinations that do not slice evenly.
    if ((DATA_W % OUT_W) != 0 || DATA_W > MAX_W || OUT_W < 1) begin : g_bad_width
        $error("fifo_word_serializer: DATA_W must be a multiple of OUT_W and <= MAX_W");
    end

    ser_state_t        state_q, state_d;
    logic [IDX_W-1:0]  beat_q, beat_d;
    logic [DATA_W-1:0] shreg_q, shreg_d;
    logic [OUT_W-1:0]  data_q, data_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              last_beat;

    function automatic logic [OUT_W-1:0] sel(input logic [DATA_W-1:0] w, input int idx);
        logic [MAX_W-1:0] t;
        t = get_beat(MAX_W'(w), idx, DATA_W, OUT_W, MSB_FIRST != 0);
        return t[OUT_W-1:0];
    endfunction

    assign last_beat = (beat_q == LAST_IDX);

    // Next-state and datapath: m_data is pre-computed so it is a flop output.
    always_comb begin
        state_d = state_q;
        beat_d  = beat_q;
        shreg_d = shreg_q;
        data_d  = data_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (en && !io.fifo_empty) state_d = POP;
            end
            POP: begin
                // fifo_dout becomes valid in the following cycle.
                state_d = LOAD;
            end
            LOAD: begin
                shreg_d = io.fifo_dout;
                beat_d  = '0;
                data_d  = sel(io.fifo_dout, 0);
                state_d = SEND;
            end
            SEND: begin
                if (io.m_ready) begin
                    if (!last_beat) begin
                        beat_d = beat_q + IDX_W'(1);
                        data_d = sel(shreg_q, int'(beat_q) + 1);
                    end else begin
                        // Word done; chain straight into the next pop if possible.
                        cnt_d   = cnt_q + CNT_W'(1);
                        state_d = (en && !io.fifo_empty) ? POP : IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers; reset discards any word in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            beat_q  <= '0;
            shreg_q <= '0;
            data_q  <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            beat_q  <= beat_d;
            shreg_q <= shreg_d;
            data_q  <= data_d;
            cnt_q   <= cnt_d;
        end
    end

    // Handshake outputs decode the state register only, so m_ready never
    // reaches m_valid combinationally.
    assign io.fifo_rd_en = (state_q == POP);
    assign io.m_valid    = (state_q == SEND);
    assign io.m_last     = (state_q == SEND) && last_beat;
    assign io.m_data     = data_q;
    assign busy          = (state_q != IDLE);
    assign word_cnt      = cnt_q;

endmodule
